vs_operand_issue: RTL and testbench
===================================

Name: vs_operand_issue

Overview:
- Upstream neighbour of shader_core. Accepts decoded vertex-shader instructions and holds a 16-entry x 128-bit temp register file.
- Reads both source operands and issues one ALU op to shader_core (oValid/oA/oB/oALU_Op). Waits for the core's ready pulse, then writes the result back to the destination register.
- Exactly one op outstanding at a time. No scoreboard needed; RAW hazards cannot occur.

Parameters:
- NUM_REGS, 16, number of temp vector registers
- REG_AW, 4, register address width (log2 NUM_REGS)
- DATA_W, 128, vector width; four 32-bit lanes {X,Y,Z,W}, X at [127:96]
- OP_W, 6, ALU opcode width (matches shader_core iALU_Op)

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- iInstValid  in  1  instruction valid
- oInstReady  out  1  block can accept an instruction
- iInst  in  34  {op[33:28], dst[27:24], srcA[23:20], srcB[19:16], swzA[15:8], swzB[7:0]}
- oValid  out  1  one-cycle issue strobe to shader_core iValid
- oA  out  DATA_W  operand A to shader_core iA
- oB  out  DATA_W  operand B to shader_core iB
- oALU_Op  out  OP_W  opcode to shader_core iALU_Op
- iResult  in  DATA_W  shader_core oResult
- iReady  in  1  shader_core oReady (completion pulse)
- iRegWe  in  1  host preload write enable
- iRegWAddr  in  REG_AW  host write address
- iRegWData  in  DATA_W  host write data
- iRegRAddr  in  REG_AW  debug read address
- oRegRData  out  DATA_W  debug read data, registered, 1-cycle latency
- oRetire  out  1  one-cycle pulse when writeback occurs
- oBusy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, WB. Encoding comes from the package.
- Reset (async): state=IDLE; all regfile entries=0; outputs oValid, oA, oB, oALU_Op, oRetire, oRegRData=0; oBusy=0; oInstReady=1 once reset is released.
- IDLE: oInstReady=1.
  - Accept on iInstValid&oInstReady at cycle T.
  - At T, capture op/dst and register the regfile reads of srcA/srcB (with swizzle applied) into oA/oB.
  - Go to ISSUE.
- ISSUE (T+1): oValid=1 for exactly this cycle with stable oA/oB/oALU_Op; go to WAIT.
- WAIT: hold oA/oB/oALU_Op. When iReady=1, capture iResult and go to WB. No timeout.
- WB: write captured result to rf[dst]; oRetire=1; go to IDLE. The next instruction is accepted no earlier than WB+1 and observes the new value.
- iReady in IDLE, ISSUE or WB: ignored.
- Host write: performed in any state.
  - Same cycle and same address as WB: the WB write takes effect; the host write is dropped.
  - Same cycle as instruction acceptance with the same address as a source: the old value is read (no bypass).
- Debug read port is independent of the FSM and reflects writes from the previous cycle.
- srcA==srcB and dst==src are both legal.
- Reset asserted mid-operation: abandon the op and drop any pending result. A late iReady after reset is ignored because state is IDLE.

Optional Feature:
- Macro VS_SWIZZLE_EN.
- Defined:
  - Each output lane selects a source lane via 2 bits (0=X, 1=Y, 2=Z, 3=W).
  - swz[7:6] controls X, [5:4] controls Y, [3:2] controls Z, [1:0] controls W.
  - Identity is 8'b00_01_10_11.
- Undefined: swizzle fields are ignored and operands pass unmodified; the swizzle mux logic is absent.

Decomposition:
- Shared package/header vshader_defs holds:
  - opcode defines (`OP_DP4 etc., shared with shader_core)
  - FSM state encodings
  - instruction field bit positions
  - SWZ_IDENTITY constant
  - lane index constants
- One sub-module vs_regfile:
  - NUM_REGS x DATA_W flops, async clear
  - two combinational read ports
  - one registered debug read port
  - one write port with WB-over-host priority

Test Plan:
- Preload: host writes rf[1]=128'h0000ABCD_00001234_00002345_00003456 and rf[2]=128'h0000BCDA_00002341_00003452_00004563. Debug-read both -> values match one cycle after the address is applied.
- Issue {OP_DP4, dst=3, srcA=1, srcB=2, identity swizzles}; stub core asserts iReady 4 cycles after oValid with iResult=128'hDEADBEEF -> oValid high for exactly 1 cycle with oA=rf[1], oB=rf[2]; oRetire pulses 1 cycle later; rf[3]=128'hDEADBEEF; oInstReady low from T+1 until WB+1.
- Back-to-back: instruction 2 reads src=3 while iInstValid is held high -> accepted only after WB; oA equals 128'hDEADBEEF.
- With VS_SWIZZLE_EN, swzA=8'b11_10_01_00 on rf[1] -> oA=128'h00003456_00002345_00001234_0000ABCD. Without the macro -> oA unchanged.
- Collision: host write to rf[3]=1 in the same cycle as WB to dst=3 -> rf[3] holds the core result. Spurious iReady in IDLE -> no write and no oRetire.
- Assert resetn during WAIT -> all outputs 0; rf cleared to 0; a later iReady produces no retire; oInstReady=1 after release.

Source files
------------

// File: rtl/vshader_defs.sv
// Shared vertex-shader definitions: opcodes, issue FSM encoding, instruction
// field positions and swizzle helpers used by vs_operand_issue and shader_core.
package vshader_defs;

    localparam int VS_NUM_REGS = 16;
    localparam int VS_REG_AW   = 4;
    localparam int VS_DATA_W   = 128;
    localparam int VS_OP_W     = 6;
    localparam int VS_LANE_W   = 32;
    localparam int VS_INST_W   = 34;

    // ALU opcodes, shared with shader_core iALU_Op
    localparam logic [VS_OP_W-1:0] OP_ADD = 6'h00;
    localparam logic [VS_OP_W-1:0] OP_MUL = 6'h01;
    localparam logic [VS_OP_W-1:0] OP_MAD = 6'h02;
    localparam logic [VS_OP_W-1:0] OP_DP3 = 6'h03;
    localparam logic [VS_OP_W-1:0] OP_DP4 = 6'h04;
    localparam logic [VS_OP_W-1:0] OP_MOV = 6'h05;

    // Instruction field positions (LSB of each field)
    localparam int INST_OP_LSB   = 28;
    localparam int INST_DST_LSB  = 24;
    localparam int INST_SRCA_LSB = 20;
    localparam int INST_SRCB_LSB = 16;
    localparam int INST_SWZA_LSB = 8;
    localparam int INST_SWZB_LSB = 0;
    localparam int SWZ_W         = 8;

    localparam logic [SWZ_W-1:0] SWZ_IDENTITY = 8'b00_01_10_11;

    // Lane indices; lane 0 (X) occupies the most significant 32 bits
    localparam logic [1:0] LANE_X = 2'd0;
    localparam logic [1:0] LANE_Y = 2'd1;
    localparam logic [1:0] LANE_Z = 2'd2;
    localparam logic [1:0] LANE_W = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } vs_state_e;

    function automatic logic [VS_LANE_W-1:0] get_lane(input logic [VS_DATA_W-1:0] v,
                                                      input logic [1:0] idx);
        logic [VS_LANE_W-1:0] lane;
        lane = '0;
        case (idx)
            LANE_X:  lane = v[127:96];
            LANE_Y:  lane = v[95:64];
            LANE_Z:  lane = v[63:32];
            default: lane = v[31:0];
        endcase
        return lane;
    endfunction

    // Output lane i takes the source lane named by the 2-bit selector at swz[7-2i -: 2]
    function automatic logic [VS_DATA_W-1:0] swizzle(input logic [VS_DATA_W-1:0] v,
                                                     input logic [SWZ_W-1:0] swz);
        return {get_lane(v, swz[7:6]), get_lane(v, swz[5:4]),
                get_lane(v, swz[3:2]), get_lane(v, swz[1:0])};
    endfunction

endpackage

// File: rtl/vs_regfile.sv
// Temp vector register file: async-clear flops, two combinational read ports,
// a registered debug read port and one write port where writeback beats host.
module vs_regfile
    import vshader_defs::*;
#(
    parameter int NUM_REGS = VS_NUM_REGS,
    parameter int REG_AW   = VS_REG_AW,
    parameter int DATA_W   = VS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    logic [DATA_W-1:0] dbg_data_q;
    logic [DATA_W-1:0] dbg_data_d;

    // Reads see the pre-edge contents: no write-to-read bypass
    assign ra_data = rf_q[ra_addr];
    assign rb_data = rf_q[rb_addr];
    assign dbg_data = dbg_data_q;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (host_we) begin
            rf_d[host_addr] = host_data;
        end
        // Applied last so a same-address writeback overrides the host write
        if (wb_we) begin
            rf_d[wb_addr] = wb_data;
        end
        dbg_data_d = rf_q[dbg_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            dbg_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
            dbg_data_q <= dbg_data_d;
        end
    end

endmodule

// File: rtl/vs_operand_issue.sv
// Vertex-shader operand fetch and single-outstanding issue to shader_core.
// Optional operand swizzle enabled by defining VS_SWIZZLE_EN.
module vs_operand_issue
    import vshader_defs::*;
#(
    parameter int NUM_REGS = VS_NUM_REGS,
    parameter int REG_AW   = VS_REG_AW,
    parameter int DATA_W   = VS_DATA_W,
    parameter int OP_W     = VS_OP_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 iInstValid,
    output logic                 oInstReady,
    input  logic [VS_INST_W-1:0] iInst,
    output logic                 oValid,
    output logic [DATA_W-1:0]    oA,
    output logic [DATA_W-1:0]    oB,
    output logic [OP_W-1:0]      oALU_Op,
    input  logic [DATA_W-1:0]    iResult,
    input  logic                 iReady,
    input  logic                 iRegWe,
    input  logic [REG_AW-1:0]    iRegWAddr,
    input  logic [DATA_W-1:0]    iRegWData,
    input  logic [REG_AW-1:0]    iRegRAddr,
    output logic [DATA_W-1:0]    oRegRData,
    output logic                 oRetire,
    output logic                 oBusy
);

    // Handshake: an instruction transfers on any rising edge where
    // iInstValid && oInstReady; oValid is a single-cycle strobe with no back-pressure,
    // and iReady is honoured only in WAIT.
    vs_state_e         state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              wb_we;

    logic [OP_W-1:0]   inst_op;
    logic [REG_AW-1:0] inst_dst;
    logic [REG_AW-1:0] inst_src_a;
    logic [REG_AW-1:0] inst_src_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign inst_op    = iInst[INST_OP_LSB +: OP_W];
    assign inst_dst   = iInst[INST_DST_LSB +: REG_AW];
    assign inst_src_a = iInst[INST_SRCA_LSB +: REG_AW];
    assign inst_src_b = iInst[INST_SRCB_LSB +: REG_AW];

`ifdef VS_SWIZZLE_EN
    assign opnd_a = swizzle(rd_a, iInst[INST_SWZA_LSB +: SWZ_W]);
    assign opnd_b = swizzle(rd_b, iInst[INST_SWZB_LSB +: SWZ_W]);
`else
    logic unused_swz;
    assign unused_swz = ^iInst[INST_SWZA_LSB +: 2*SWZ_W];
    assign opnd_a     = rd_a;
    assign opnd_b     = rd_b;
`endif

    vs_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .DATA_W   (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (resetn),
        .ra_addr   (inst_src_a),
        .ra_data   (rd_a),
        .rb_addr   (inst_src_b),
        .rb_data   (rd_b),
        .wb_we     (wb_we),
        .wb_addr   (dst_q),
        .wb_data   (res_q),
        .host_we   (iRegWe),
        .host_addr (iRegWAddr),
        .host_data (iRegWData),
        .dbg_addr  (iRegRAddr),
        .dbg_data  (oRegRData)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        wb_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iInstValid) begin
                    op_d    = inst_op;
                    dst_d   = inst_dst;
                    a_d     = opnd_a;
                    b_d     = opnd_b;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (iReady) begin
                    res_d   = iResult;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                wb_we   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Ready is held low while reset is asserted so nothing is offered mid-reset
    assign oInstReady = (state_q == ST_IDLE) && resetn;
    assign oValid     = (state_q == ST_ISSUE);
    assign oRetire    = (state_q == ST_WB);
    assign oBusy      = (state_q != ST_IDLE);
    assign oA         = a_q;
    assign oB         = b_q;
    assign oALU_Op    = op_q;

endmodule

// File: tb/tb_vs_operand_issue.sv
// Directed self-checking bench for vs_operand_issue with a stubbed shader_core.
module tb_vs_operand_issue;
  import vshader_defs::*;

  localparam logic [127:0] D1 = 128'h0000ABCD_00001234_00002345_00003456;
  localparam logic [127:0] D2 = 128'h0000BCDA_00002341_00003452_00004563;
  localparam logic [127:0] R1 = 128'hDEADBEEF;
  localparam logic [127:0] R2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] R3 = 128'hCAFEF00D_0BADC0DE_FEEDFACE_12345678;
  localparam logic [127:0] RS = 128'h99999999_99999999_99999999_99999999;
  localparam logic [7:0]   SWZ_REV = 8'b11_10_01_00;

  logic         clk;
  logic         resetn;
  logic         iInstValid;
  logic         oInstReady;
  logic [33:0]  iInst;
  logic         oValid;
  logic [127:0] oA;
  logic [127:0] oB;
  logic [5:0]   oALU_Op;
  logic [127:0] iResult;
  logic         iReady;
  logic         iRegWe;
  logic [3:0]   iRegWAddr;
  logic [127:0] iRegWData;
  logic [3:0]   iRegRAddr;
  logic [127:0] oRegRData;
  logic         oRetire;
  logic         oBusy;

  int checks;
  int failures;
  logic [127:0] exp_swz_a;

  vs_operand_issue dut (
    .clk        (clk),
    .resetn     (resetn),
    .iInstValid (iInstValid),
    .oInstReady (oInstReady),
    .iInst      (iInst),
    .oValid     (oValid),
    .oA         (oA),
    .oB         (oB),
    .oALU_Op    (oALU_Op),
    .iResult    (iResult),
    .iReady     (iReady),
    .iRegWe     (iRegWe),
    .iRegWAddr  (iRegWAddr),
    .iRegWData  (iRegWData),
    .iRegRAddr  (iRegRAddr),
    .oRegRData  (oRegRData),
    .oRetire    (oRetire),
    .oBusy      (oBusy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [33:0] mk(input logic [5:0] op, input logic [3:0] dst,
                                     input logic [3:0] sa, input logic [3:0] sb,
                                     input logic [7:0] swa, input logic [7:0] swb);
    return {op, dst, sa, sb, swa, swb};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [127:0] exp);
    iRegRAddr = addr;
    step();
    chk(tag, oRegRData, exp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
`ifdef VS_SWIZZLE_EN
    exp_swz_a = 128'h00003456_00002345_00001234_0000ABCD;
`else
    exp_swz_a = D1;
`endif
    resetn = 1'b0;
    iInstValid = 1'b0;
    iInst = '0;
    iResult = '0;
    iReady = 1'b0;
    iRegWe = 1'b0;
    iRegWAddr = '0;
    iRegWData = '0;
    iRegRAddr = '0;

    // reset state
    step();
    step();
    chk("rst_valid", oValid, 0);
    chk("rst_a", oA, 0);
    chk("rst_op", oALU_Op, 0);
    chk("rst_retire", oRetire, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_dbg", oRegRData, 0);
    resetn = 1'b1;
    step();
    chk("post_rst_ready", oInstReady, 1);

    // preload and debug read-back
    iRegWe = 1'b1; iRegWAddr = 4'd1; iRegWData = D1;
    step();
    iRegWAddr = 4'd2; iRegWData = D2; iRegRAddr = 4'd1;
    step();
    chk("dbg_rf1", oRegRData, D1);
    iRegWe = 1'b0; iRegRAddr = 4'd2;
    step();
    chk("dbg_rf2", oRegRData, D2);

    // instruction 1: DP4 r3 = r1, r2
    iInst = mk(OP_DP4, 4'd3, 4'd1, 4'd2, SWZ_IDENTITY, SWZ_IDENTITY);
    iInstValid = 1'b1;
    chk("i1_ready_idle", oInstReady, 1);
    step();
    chk("i1_valid", oValid, 1);
    chk("i1_a", oA, D1);
    chk("i1_b", oB, D2);
    chk("i1_op", oALU_Op, OP_DP4);
    chk("i1_ready_low", oInstReady, 0);
    chk("i1_busy", oBusy, 1);
    // instruction 2 held pending: ADD r4 = r3, r1
    iInst = mk(OP_ADD, 4'd4, 4'd3, 4'd1, SWZ_IDENTITY, SWZ_IDENTITY);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("i1_wait_valid", oValid, 0);
      chk("i1_wait_ready", oInstReady, 0);
      chk("i1_wait_a", oA, D1);
    end
    iReady = 1'b1; iResult = R1;
    step();
    chk("i1_retire", oRetire, 1);
    chk("i1_wb_ready", oInstReady, 0);
    chk("i1_wb_valid", oValid, 0);
    iReady = 1'b0; iResult = '0;
    step();
    chk("i1_retire_end", oRetire, 0);
    chk("i1_ready_back", oInstReady, 1);

    // instruction 2 accepted after writeback and sees the new r3
    step();
    chk("i2_valid", oValid, 1);
    chk("i2_a", oA, R1);
    chk("i2_b", oB, D1);
    chk("i2_op", oALU_Op, OP_ADD);
    iInstValid = 1'b0;
    step();
    step();
    iReady = 1'b1; iResult = R2;
    step();
    chk("i2_retire", oRetire, 1);
    iReady = 1'b0; iResult = '0;
    step();
    read_chk("rf3_after_i1", 4'd3, R1);
    read_chk("rf4_after_i2", 4'd4, R2);

    // instruction 3: swizzled A, writeback collides with host write to r3
    iInst = mk(OP_MUL, 4'd3, 4'd1, 4'd2, SWZ_REV, SWZ_IDENTITY);
    iInstValid = 1'b1;
    step();
    iInstValid = 1'b0;
    chk("i3_valid", oValid, 1);
    chk("i3_swz_a", oA, exp_swz_a);
    chk("i3_b", oB, D2);
    step();
    iReady = 1'b1; iResult = R3;
    step();
    chk("i3_retire", oRetire, 1);
    iReady = 1'b0; iResult = '0;
    iRegWe = 1'b1; iRegWAddr = 4'd3; iRegWData = 128'd1;
    step();
    iRegWe = 1'b0;
    read_chk("collision_rf3", 4'd3, R3);

    // spurious iReady while idle
    iReady = 1'b1; iResult = RS;
    step();
    chk("spur_retire", oRetire, 0);
    chk("spur_busy", oBusy, 0);
    step();
    chk("spur_retire2", oRetire, 0);
    iReady = 1'b0; iResult = '0;
    read_chk("spur_rf3", 4'd3, R3);
    read_chk("spur_rf0", 4'd0, 0);

    // reset during WAIT abandons the op
    iInst = mk(OP_DP4, 4'd6, 4'd1, 4'd2, SWZ_IDENTITY, SWZ_IDENTITY);
    iInstValid = 1'b1;
    step();
    iInstValid = 1'b0;
    step();
    chk("rw_busy", oBusy, 1);
    resetn = 1'b0;
    #1;
    chk("rw_valid", oValid, 0);
    chk("rw_a", oA, 0);
    chk("rw_b", oB, 0);
    chk("rw_op", oALU_Op, 0);
    chk("rw_retire", oRetire, 0);
    chk("rw_busy0", oBusy, 0);
    chk("rw_dbg", oRegRData, 0);
    step();
    resetn = 1'b1;
    iReady = 1'b1; iResult = R2;
    step();
    chk("rw_late_retire", oRetire, 0);
    chk("rw_late_busy", oBusy, 0);
    chk("rw_ready", oInstReady, 1);
    step();
    chk("rw_late_retire2", oRetire, 0);
    iReady = 1'b0; iResult = '0;
    read_chk("rw_rf1_clear", 4'd1, 0);
    read_chk("rw_rf3_clear", 4'd3, 0);
    read_chk("rw_rf6_clear", 4'd6, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
